// File: rtl/mips_pkg.sv
// Shared MIPS32 decode definitions: opcodes, instruction classes, IR field positions.
package mips_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int IMM_HI = 15;

    typedef enum logic [2:0] {
        TYPE_RR_ALU = 3'd0,
        TYPE_RM_ALU = 3'd1,
        TYPE_LOAD   = 3'd2,
        TYPE_STORE  = 3'd3,
        TYPE_BRANCH = 3'd4,
        TYPE_HALT   = 3'd5,
        TYPE_NOP    = 3'd6
    } instr_type_e;

    function automatic instr_type_e classify(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: classify = TYPE_RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     classify = TYPE_RM_ALU;
            OP_LW:                                         classify = TYPE_LOAD;
            OP_SW:                                         classify = TYPE_STORE;
            OP_BNEQZ, OP_BEQZ:                             classify = TYPE_BRANCH;
            OP_HLT:                                        classify = TYPE_HALT;
            default:                                       classify = TYPE_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 2-read / 1-write GPR file with R0 hardwired to zero.
// ID_WB_BYPASS_EN defined: same-cycle write data is forwarded to the read ports (write-first).
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_wr_idx,
    input  logic [DATA_W-1:0]    i_wr_data,
    input  logic [REG_IDX_W-1:0] i_rs_idx,
    input  logic [REG_IDX_W-1:0] i_rt_idx,
    output logic [DATA_W-1:0]    o_rs_data,
    output logic [DATA_W-1:0]    o_rt_data
);

    logic [DATA_W-1:0] r_gpr [NUM_REGS];
    logic              w_wr_live;

    assign w_wr_live = i_we && (i_wr_idx != '0);

    // NOTE: the register array is reset explicitly because all GPRs must read 0 after reset;
    // this costs a reset on every bit, so plain storage arrays normally leave it out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_gpr[i] <= '0;
        end else if (w_wr_live) begin
            r_gpr[i_wr_idx] <= i_wr_data;
        end
    end

    // NOTE: every output gets a default first so no path through always_comb infers a latch.
    always_comb begin
        o_rs_data = (i_rs_idx == '0) ? '0 : r_gpr[i_rs_idx];
        o_rt_data = (i_rt_idx == '0) ? '0 : r_gpr[i_rt_idx];
`ifdef ID_WB_BYPASS_EN
        if (w_wr_live && (i_wr_idx == i_rs_idx)) o_rs_data = i_wr_data;
        if (w_wr_live && (i_wr_idx == i_rt_idx)) o_rt_data = i_wr_data;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// MIPS32 decode stage: register read, immediate extend, classify, hazard stall/flush into ID/EX.
// ID_WB_BYPASS_EN selects WB->ID forwarding instead of a one-cycle RAW stall.
module id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 HALTED,
    input  logic [31:0]          IF_ID_IR,
    input  logic [31:0]          IF_ID_NPC,
    input  logic [31:0]          EX_MEM_IR,
    input  logic                 EX_MEM_COND,
    input  logic                 MEM_WB_WE,
    input  logic [REG_IDX_W-1:0] MEM_WB_RD,
    input  logic [DATA_W-1:0]    MEM_WB_DATA,
    output logic                 PCWrite,
    output logic                 IF_ID_Write,
    output logic [31:0]          ID_EX_IR,
    output logic [31:0]          ID_EX_NPC,
    output logic [DATA_W-1:0]    ID_EX_A,
    output logic [DATA_W-1:0]    ID_EX_B,
    output logic [DATA_W-1:0]    ID_EX_IMM,
    output logic [2:0]           ID_EX_TYPE
);

    logic [31:0]          r_ir;
    logic [31:0]          r_npc;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [DATA_W-1:0]    r_imm;
    instr_type_e          r_type;
    logic                 r_halt_seen;

    logic [5:0]           w_op;
    logic [REG_IDX_W-1:0] w_rs;
    logic [REG_IDX_W-1:0] w_rt;
    logic [REG_IDX_W-1:0] w_ld_rt;
    instr_type_e          w_if_type;
    logic                 w_uses_rt;
    logic                 w_load_use;
    logic                 w_wb_haz;
    logic                 w_stall;
    logic                 w_taken;
    logic                 w_bubble;
    logic [DATA_W-1:0]    w_rs_data;
    logic [DATA_W-1:0]    w_rt_data;
    logic [DATA_W-1:0]    w_imm;
    logic [5:0]           w_ex_op;
    logic                 w_unused;

    assign w_op      = IF_ID_IR[OP_HI:OP_LO];
    assign w_rs      = IF_ID_IR[RS_HI:RS_LO];
    assign w_rt      = IF_ID_IR[RT_HI:RT_LO];
    assign w_if_type = classify(w_op);
    assign w_uses_rt = (w_if_type == TYPE_RR_ALU) || (w_if_type == TYPE_STORE);
    assign w_imm     = {{(DATA_W-IMM_HI-1){IF_ID_IR[IMM_HI]}}, IF_ID_IR[IMM_HI:0]};

    mips_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (MEM_WB_WE),
        .i_wr_idx  (MEM_WB_RD),
        .i_wr_data (MEM_WB_DATA),
        .i_rs_idx  (w_rs),
        .i_rt_idx  (w_rt),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data)
    );

    // rt only counts as a source for register-register ALU ops and stores.
    assign w_ld_rt    = r_ir[RT_HI:RT_LO];
    assign w_load_use = (r_type == TYPE_LOAD) && (w_ld_rt != '0) &&
                        ((w_ld_rt == w_rs) || (w_uses_rt && (w_ld_rt == w_rt)));
`ifdef ID_WB_BYPASS_EN
    assign w_wb_haz   = 1'b0;
`else
    assign w_wb_haz   = MEM_WB_WE && (MEM_WB_RD != '0) &&
                        ((MEM_WB_RD == w_rs) || (w_uses_rt && (MEM_WB_RD == w_rt)));
`endif
    assign w_stall    = w_load_use || w_wb_haz;

    assign w_ex_op  = EX_MEM_IR[OP_HI:OP_LO];
    assign w_taken  = ((w_ex_op == OP_BNEQZ) && !EX_MEM_COND) ||
                      ((w_ex_op == OP_BEQZ)  &&  EX_MEM_COND);
    assign w_bubble = w_taken || w_stall || r_halt_seen;
    assign w_unused = &{1'b0, EX_MEM_IR[RS_HI:0]};

    // A taken branch overrides a stall: the stalled instruction is on the wrong path anyway.
    assign PCWrite     = !HALTED && (w_taken || !w_stall);
    assign IF_ID_Write = !HALTED && (w_taken || !w_stall);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ir        <= '0;
            r_npc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_type      <= TYPE_NOP;
            r_halt_seen <= 1'b0;
        end else if (!HALTED) begin
            if (w_bubble) begin
                r_ir   <= '0;
                r_npc  <= '0;
                r_a    <= '0;
                r_b    <= '0;
                r_imm  <= '0;
                r_type <= TYPE_NOP;
            end else begin
                r_ir   <= IF_ID_IR;
                r_npc  <= IF_ID_NPC;
                r_a    <= w_rs_data;
                r_b    <= w_rt_data;
                r_imm  <= w_imm;
                r_type <= w_if_type;
            end
            if (w_taken)
                r_halt_seen <= 1'b0;
            else if (!w_bubble && (w_if_type == TYPE_HALT))
                r_halt_seen <= 1'b1;
        end
    end

    assign ID_EX_IR   = r_ir;
    assign ID_EX_NPC  = r_npc;
    assign ID_EX_A    = r_a;
    assign ID_EX_B    = r_b;
    assign ID_EX_IMM  = r_imm;
    assign ID_EX_TYPE = r_type;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios, then random traffic against a behavioural model.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic        HALTED;
    logic [31:0] IF_ID_IR;
    logic [31:0] IF_ID_NPC;
    logic [31:0] EX_MEM_IR;
    logic        EX_MEM_COND;
    logic        MEM_WB_WE;
    logic [4:0]  MEM_WB_RD;
    logic [31:0] MEM_WB_DATA;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic [31:0] ID_EX_IR;
    logic [31:0] ID_EX_NPC;
    logic [31:0] ID_EX_A;
    logic [31:0] ID_EX_B;
    logic [31:0] ID_EX_IMM;
    logic [2:0]  ID_EX_TYPE;

    id_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .HALTED      (HALTED),
        .IF_ID_IR    (IF_ID_IR),
        .IF_ID_NPC   (IF_ID_NPC),
        .EX_MEM_IR   (EX_MEM_IR),
        .EX_MEM_COND (EX_MEM_COND),
        .MEM_WB_WE   (MEM_WB_WE),
        .MEM_WB_RD   (MEM_WB_RD),
        .MEM_WB_DATA (MEM_WB_DATA),
        .PCWrite     (PCWrite),
        .IF_ID_Write (IF_ID_Write),
        .ID_EX_IR    (ID_EX_IR),
        .ID_EX_NPC   (ID_EX_NPC),
        .ID_EX_A     (ID_EX_A),
        .ID_EX_B     (ID_EX_B),
        .ID_EX_IMM   (ID_EX_IMM),
        .ID_EX_TYPE  (ID_EX_TYPE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ISA opcodes and class codes, written out independently of the RTL package.
    localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4, MUL = 6'd5;
    localparam logic [5:0] LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11, SLTI = 6'd12;
    localparam logic [5:0] BNEQZ = 6'd13, BEQZ = 6'd14, HLT = 6'd63;
    localparam logic [2:0] T_RR = 3'd0, T_RM = 3'd1, T_LD = 3'd2, T_ST = 3'd3;
    localparam logic [2:0] T_BR = 3'd4, T_HLT = 3'd5, T_NOP = 3'd6;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] low);
        return {op, rs, rt, low};
    endfunction

    // Behavioural model state
    logic [2:0]  type_of [64];
    logic [31:0] gpr [32];
    logic [31:0] m_ir, m_npc, m_a, m_b, m_imm;
    logic [2:0]  m_type;
    logic        m_halt;

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (MEM_WB_WE && MEM_WB_RD == idx) return MEM_WB_DATA;
`endif
        return gpr[idx];
    endfunction

    function automatic logic model_stall();
        logic [4:0] rs, rt, ld_rt;
        logic       rt_src, hz;
        rs     = IF_ID_IR[25:21];
        rt     = IF_ID_IR[20:16];
        ld_rt  = m_ir[20:16];
        rt_src = (type_of[IF_ID_IR[31:26]] == T_RR) || (type_of[IF_ID_IR[31:26]] == T_ST);
        hz = (m_type == T_LD) && (ld_rt != 0) && (ld_rt == rs || (rt_src && ld_rt == rt));
`ifndef ID_WB_BYPASS_EN
        hz = hz || (MEM_WB_WE && MEM_WB_RD != 0 && (MEM_WB_RD == rs || (rt_src && MEM_WB_RD == rt)));
`endif
        return hz;
    endfunction

    function automatic logic model_taken();
        return (EX_MEM_IR[31:26] == BNEQZ && !EX_MEM_COND) || (EX_MEM_IR[31:26] == BEQZ && EX_MEM_COND);
    endfunction

    task automatic model_clear();
        m_ir = 0; m_npc = 0; m_a = 0; m_b = 0; m_imm = 0; m_type = T_NOP;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic tk, st;
        tk = model_taken();
        st = model_stall();
        if (!rst_n) begin
            model_clear();
            m_halt = 1'b0;
            for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
        end else begin
            if (!HALTED) begin
                if (tk || st || m_halt) begin
                    model_clear();
                end else begin
                    m_ir   = IF_ID_IR;
                    m_npc  = IF_ID_NPC;
                    m_a    = model_read(IF_ID_IR[25:21]);
                    m_b    = model_read(IF_ID_IR[20:16]);
                    m_imm  = 32'(signed'(IF_ID_IR[15:0]));
                    m_type = type_of[IF_ID_IR[31:26]];
                    if (m_type == T_HLT) m_halt = 1'b1;
                end
                if (tk) m_halt = 1'b0;
            end
            if (MEM_WB_WE && MEM_WB_RD != 0) gpr[MEM_WB_RD] = MEM_WB_DATA;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [16];
        ops = '{ADD, SUB, AND_, OR_, SLT, MUL, LW, SW, ADDI, SUBI, SLTI, BNEQZ, BEQZ, HLT, LW, 6'd0};
        ops[15] = 6'($urandom);
        return enc(ops[$urandom_range(0, 15)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   16'($urandom));
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) type_of[i] = T_NOP;
        type_of[ADD] = T_RR; type_of[SUB] = T_RR; type_of[AND_] = T_RR;
        type_of[OR_] = T_RR; type_of[SLT] = T_RR; type_of[MUL]  = T_RR;
        type_of[ADDI] = T_RM; type_of[SUBI] = T_RM; type_of[SLTI] = T_RM;
        type_of[LW] = T_LD; type_of[SW] = T_ST;
        type_of[BNEQZ] = T_BR; type_of[BEQZ] = T_BR; type_of[HLT] = T_HLT;

        rst_n = 1'b0; HALTED = 1'b0; IF_ID_IR = 32'd0; IF_ID_NPC = 32'd0;
        EX_MEM_IR = 32'd0; EX_MEM_COND = 1'b0;
        MEM_WB_WE = 1'b0; MEM_WB_RD = 5'd0; MEM_WB_DATA = 32'd0;

        // Reset state
        cyc();
        rst_n = 1'b1;
        check("rst_type", {29'd0, ID_EX_TYPE}, 32'd6);
        check("rst_a", ID_EX_A, 32'd0);
        check("rst_ir", ID_EX_IR, 32'd0);
        check("rst_pcw", {31'd0, PCWrite}, 32'd1);

        // WB R1=5, then ADDI R2,R1,#-3
        MEM_WB_WE = 1'b1; MEM_WB_RD = 5'd1; MEM_WB_DATA = 32'd5;
        cyc();
        MEM_WB_WE = 1'b0;
        IF_ID_IR = enc(ADDI, 5'd1, 5'd2, 16'hFFFD); IF_ID_NPC = 32'd11;
        cyc();
        check("addi_a", ID_EX_A, 32'd5);
        check("addi_imm", ID_EX_IMM, 32'hFFFF_FFFD);
        check("addi_type", {29'd0, ID_EX_TYPE}, 32'd1);
        check("addi_npc", ID_EX_NPC, 32'd11);

        // LW R3,0(R1) ; ADD R4,R3,R1 -> one stall cycle
        IF_ID_IR = enc(LW, 5'd1, 5'd3, 16'd0);
        cyc();
        check("lw_type", {29'd0, ID_EX_TYPE}, 32'd2);
        IF_ID_IR = enc(ADD, 5'd3, 5'd1, {5'd4, 11'd0});
        #1;
        check("lu_pcw", {31'd0, PCWrite}, 32'd0);
        check("lu_ifw", {31'd0, IF_ID_Write}, 32'd0);
        cyc();
        check("lu_bub_type", {29'd0, ID_EX_TYPE}, 32'd6);
        check("lu_bub_ir", ID_EX_IR, 32'd0);
        check("lu_release_pcw", {31'd0, PCWrite}, 32'd1);
        cyc();
        check("lu_add_type", {29'd0, ID_EX_TYPE}, 32'd0);
        check("lu_add_b", ID_EX_B, 32'd5);

        // LW R0 never stalls
        IF_ID_IR = enc(LW, 5'd1, 5'd0, 16'd4);
        cyc();
        IF_ID_IR = enc(ADD, 5'd0, 5'd1, {5'd4, 11'd0});
        #1;
        check("lw_r0_pcw", {31'd0, PCWrite}, 32'd1);
        cyc();
        check("lw_r0_type", {29'd0, ID_EX_TYPE}, 32'd0);

        // Taken branch beats load-use stall
        IF_ID_IR = enc(LW, 5'd1, 5'd3, 16'd0);
        cyc();
        IF_ID_IR = enc(ADD, 5'd3, 5'd1, {5'd4, 11'd0});
        EX_MEM_IR = enc(BEQZ, 5'd2, 5'd0, 16'd8); EX_MEM_COND = 1'b1;
        #1;
        check("br_pcw", {31'd0, PCWrite}, 32'd1);
        check("br_ifw", {31'd0, IF_ID_Write}, 32'd1);
        cyc();
        check("br_bub_type", {29'd0, ID_EX_TYPE}, 32'd6);
        EX_MEM_IR = 32'd0; EX_MEM_COND = 1'b0;

        // HLT, then everything bubbles until a taken branch
        IF_ID_IR = enc(HLT, 5'd0, 5'd0, 16'd0);
        cyc();
        check("hlt_type", {29'd0, ID_EX_TYPE}, 32'd5);
        IF_ID_IR = enc(ADD, 5'd1, 5'd1, {5'd4, 11'd0});
        cyc();
        check("hlt_next_type", {29'd0, ID_EX_TYPE}, 32'd6);
        EX_MEM_IR = enc(BNEQZ, 5'd2, 5'd0, 16'd8); EX_MEM_COND = 1'b0;
        cyc();
        EX_MEM_IR = 32'd0;
        IF_ID_IR = enc(ADDI, 5'd1, 5'd2, 16'hFFFD);
        cyc();
        check("hlt_clear_type", {29'd0, ID_EX_TYPE}, 32'd1);

        // HALTED freezes ID_EX but WB still commits
        HALTED = 1'b1; IF_ID_IR = enc(SW, 5'd1, 5'd2, 16'd0);
        MEM_WB_WE = 1'b1; MEM_WB_RD = 5'd7; MEM_WB_DATA = 32'h77;
        #1;
        check("halted_pcw", {31'd0, PCWrite}, 32'd0);
        cyc();
        check("halted_type", {29'd0, ID_EX_TYPE}, 32'd1);
        check("halted_imm", ID_EX_IMM, 32'hFFFF_FFFD);
        HALTED = 1'b0; MEM_WB_WE = 1'b0;
        IF_ID_IR = enc(ADDI, 5'd7, 5'd8, 16'd1);
        cyc();
        check("wb_in_halt_a", ID_EX_A, 32'h77);

        // Same-cycle WB of R7 and read of R7
        MEM_WB_WE = 1'b1; MEM_WB_RD = 5'd7; MEM_WB_DATA = 32'h1234;
        #1;
`ifdef ID_WB_BYPASS_EN
        check("byp_pcw", {31'd0, PCWrite}, 32'd1);
        cyc();
        MEM_WB_WE = 1'b0;
`else
        check("raw3_pcw", {31'd0, PCWrite}, 32'd0);
        cyc();
        check("raw3_bub_type", {29'd0, ID_EX_TYPE}, 32'd6);
        MEM_WB_WE = 1'b0;
        cyc();
`endif
        check("wb_read_a", ID_EX_A, 32'h1234);

        // Random traffic against the model
        rst_n = 1'b0;
        cyc();
        model_clear();
        m_halt = 1'b0;
        for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            rst_n       = ($urandom_range(0, 49) != 0);
            HALTED      = ($urandom_range(0, 15) == 0);
            IF_ID_IR    = rand_instr();
            IF_ID_NPC   = $urandom;
            case ($urandom_range(0, 5))
                0:       EX_MEM_IR = enc(BEQZ, 5'd1, 5'd0, 16'($urandom));
                1:       EX_MEM_IR = enc(BNEQZ, 5'd1, 5'd0, 16'($urandom));
                default: EX_MEM_IR = rand_instr();
            endcase
            EX_MEM_COND = 1'($urandom);
            MEM_WB_WE   = 1'($urandom);
            MEM_WB_RD   = 5'($urandom_range(0, 7));
            MEM_WB_DATA = $urandom;
            #1;
            check("rnd_pcw", {31'd0, PCWrite}, {31'd0, !HALTED && (model_taken() || !model_stall())});
            check("rnd_ifw", {31'd0, IF_ID_Write}, {31'd0, !HALTED && (model_taken() || !model_stall())});
            @(posedge clk);
            model_edge();
            #1;
            check("rnd_ir", ID_EX_IR, m_ir);
            check("rnd_type", {29'd0, ID_EX_TYPE}, {29'd0, m_type});
            check("rnd_npc", ID_EX_NPC, m_npc);
            check("rnd_a", ID_EX_A, m_a);
            check("rnd_b", ID_EX_B, m_b);
            check("rnd_imm", ID_EX_IMM, m_imm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
